// File: rtl/dsp_program_sequencer.sv
// Per-sample instruction sequencer: on an accepted sample tick it streams the
// program from instruction memory to the core, waits for the pipeline to drain, then flags completion.
module dsp_program_sequencer #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int IMEM_LATENCY    = 2,
  parameter int PIPE_DEPTH      = 4,
  parameter int OVR_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       sample_tick,
  input  logic [PROG_ADDR_WIDTH:0]   prog_length,
  output logic [PROG_ADDR_WIDTH-1:0] imem_rd_addr,
  output logic                       imem_rd_en,
  input  logic [INSTR_WIDTH-1:0]     imem_rd_data,
  output logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [OVR_CNT_WIDTH-1:0]   overrun_count,
  output logic [1:0]                 dbg_state
);

  localparam int DRAIN_CYCLES = IMEM_LATENCY + PIPE_DEPTH;
  localparam int DW           = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e                     state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PROG_ADDR_WIDTH:0]   len_q, len_d;
  logic [DW-1:0]              drain_q, drain_d;
  logic [IMEM_LATENCY-1:0]    valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       frame_done_q, frame_done_d;
  logic                       overrun_q, overrun_d;
  logic [OVR_CNT_WIDTH-1:0]   ovr_cnt_q, ovr_cnt_d;
  logic                       accept;

  assign accept = (state_q == S_IDLE) && enable && sample_tick;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      len_q        <= '0;
      drain_q      <= '0;
      valid_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      ovr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      len_q        <= len_d;
      drain_q      <= drain_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      ovr_cnt_q    <= ovr_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    len_d        = len_q;
    drain_d      = drain_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d = prog_length;
          pc_d  = '0;
          if (prog_length != '0) state_d = S_RUN;
          else                   frame_done_d = 1'b1;
        end
      end
      S_RUN: begin
        // pc wraps naturally for a full-size program
        pc_d = pc_q + 1'b1;
        if ({1'b0, pc_q} == len_q - 1'b1) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Bit 0 is the registered read enable; the last bit marks data arriving at the core
    valid_d   = IMEM_LATENCY'({valid_q, (state_d == S_RUN)});
    busy_d    = (state_d != S_IDLE);
    overrun_d = sample_tick && busy_q;
    ovr_cnt_d = (overrun_d && (ovr_cnt_q != '1)) ? ovr_cnt_q + 1'b1 : ovr_cnt_q;
  end

  // Outputs
  always_comb begin
    imem_rd_en    = valid_q[0];
    imem_rd_addr  = pc_q;
    instruction   = valid_q[IMEM_LATENCY-1] ? imem_rd_data : '0;
    busy          = busy_q;
    frame_done    = frame_done_q;
    overrun       = overrun_q;
    overrun_count = ovr_cnt_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_dsp_program_sequencer.sv
// Directed bench for dsp_program_sequencer: frame timing, overrun, back-to-back,
// zero-length frames, mid-frame reset and counter saturation.
module tb_dsp_program_sequencer;

  localparam int IW = 26;
  localparam int AW = 10;
  localparam int LAT = 2;
  localparam int DEPTH = 4;
  localparam int OW = 4;
  localparam int D = LAT + DEPTH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic          sample_tick = 1'b0;
  logic [AW:0]   prog_length = '0;
  logic [AW-1:0] imem_rd_addr;
  logic          imem_rd_en;
  logic [IW-1:0] imem_rd_data = '0;
  logic [IW-1:0] instruction;
  logic          busy, frame_done, overrun;
  logic [OW-1:0] overrun_count;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  dsp_program_sequencer #(
    .INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW), .IMEM_LATENCY(LAT),
    .PIPE_DEPTH(DEPTH), .OVR_CNT_WIDTH(OW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_tick(sample_tick),
    .prog_length(prog_length), .imem_rd_addr(imem_rd_addr), .imem_rd_en(imem_rd_en),
    .imem_rd_data(imem_rd_data), .instruction(instruction), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .overrun_count(overrun_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
    logic [5:0] op;
    op = 6'h2A ^ a[5:0];
    return {op, a, ~a};
  endfunction

  // Instruction memory model: data for address in cycle c is presented in cycle c+1
  always @(posedge clk) imem_rd_data <= word_of(imem_rd_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++; if (instruction !== '0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instruction); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overrun_count !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", overrun_count); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    reset_n = 1'b1;
    step();
  endtask

  // Starts a frame of length len in the current cycle and checks every output cycle by cycle
  task automatic test_frame(input int len, input int ovr_at);
    logic [IW-1:0] e_instr;
    prog_length = (AW+1)'(len);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    prog_length = 11'd7;
    for (int j = 1; j <= len + D + 2; j++) begin
      e_instr = (j >= 2 && j <= len + 1) ? word_of(AW'(j - 2)) : '0;
      checks++; if (imem_rd_en !== (j <= len)) begin errors++; $display("FAIL frame_rd_en j=%0d got=%b exp=%b", j, imem_rd_en, (j <= len)); end
      if (j <= len) begin
        checks++; if (imem_rd_addr !== AW'(j - 1)) begin errors++; $display("FAIL frame_addr j=%0d got=%0d exp=%0d", j, imem_rd_addr, j - 1); end
      end
      checks++; if (instruction !== e_instr) begin errors++; $display("FAIL frame_instr j=%0d got=%h exp=%h", j, instruction, e_instr); end
      checks++; if (busy !== (j <= len + D)) begin errors++; $display("FAIL frame_busy j=%0d got=%b exp=%b", j, busy, (j <= len + D)); end
      checks++; if (frame_done !== (j == len + D + 1)) begin errors++; $display("FAIL frame_done j=%0d got=%b exp=%b", j, frame_done, (j == len + D + 1)); end
      checks++; if (overrun !== (ovr_at > 0 && j == ovr_at + 1)) begin errors++; $display("FAIL frame_overrun j=%0d got=%b", j, overrun); end
      sample_tick = (j == ovr_at);
      step();
    end
    sample_tick = 1'b0;
    if (ovr_at > 0 && exp_cnt < (1 << OW) - 1) exp_cnt++;
    checks++; if (overrun_count !== OW'(exp_cnt)) begin errors++; $display("FAIL frame_count got=%0d exp=%0d", overrun_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    prog_length = 11'd2;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (2 + D) step();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", frame_done); end
    prog_length = 11'd1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    enable = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    checks++; if (imem_rd_en !== 1'b1 || imem_rd_addr !== '0) begin errors++; $display("FAIL b2b_fetch got=%b/%0d exp=1/0", imem_rd_en, imem_rd_addr); end
    step();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    n = 2;
    while (frame_done !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (n != 1 + D + 1) begin errors++; $display("FAIL b2b_done2 got_cycle=%0d exp=%0d", n, 1 + D + 1); end
    enable = 1'b1;
    step();
  endtask

  task automatic test_len_zero();
    prog_length = '0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", frame_done); end
    checks++; if (busy !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL zero_idle busy=%b rd_en=%b exp=0/0", busy, imem_rd_en); end
    step();
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after done=%b busy=%b exp=0/0", frame_done, busy); end
  endtask

  task automatic test_mid_reset();
    int seen;
    prog_length = 11'd3;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    checks++; if (instruction !== word_of(10'd0)) begin errors++; $display("FAIL mrst_word0 got=%h exp=%h", instruction, word_of(10'd0)); end
    reset_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++; if (instruction !== '0) begin errors++; $display("FAIL mrst_instr got=%h exp=0", instruction); end
    checks++; if (busy !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL mrst_busy busy=%b rd_en=%b exp=0/0", busy, imem_rd_en); end
    checks++; if (overrun_count !== '0) begin errors++; $display("FAIL mrst_cnt got=%0d exp=0", overrun_count); end
    step();
    reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (frame_done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mrst_no_done got=%0d exp=0", seen); end
    test_frame(3, 0);
  endtask

  task automatic test_saturation();
    int n;
    prog_length = 11'd40;
    sample_tick = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      sample_tick = 1'b1;
      step();
      if (exp_cnt < (1 << OW) - 1) exp_cnt++;
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL sat_pulse i=%0d got=%b exp=1", i, overrun); end
      checks++; if (overrun_count !== OW'(exp_cnt)) begin errors++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, overrun_count, exp_cnt); end
    end
    sample_tick = 1'b0;
    step();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sat_quiet got=%b exp=0", overrun); end
    n = 0;
    while (frame_done !== 1'b1 && n < 80) begin step(); n++; end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL sat_frame_done timeout after %0d cycles", n); end
    enable = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL dis_tick busy=%b overrun=%b exp=0/0", busy, overrun); end
    step();
    checks++; if (imem_rd_en !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL dis_idle rd_en=%b done=%b exp=0/0", imem_rd_en, frame_done); end
    checks++; if (overrun_count !== OW'(exp_cnt)) begin errors++; $display("FAIL dis_cnt got=%0d exp=%0d", overrun_count, exp_cnt); end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frame(3, 0);
    test_frame(3, 5);
    test_frame(5, 0);
    test_back_to_back();
    test_len_zero();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
